// File: rtl/lab_pkg.sv
// Shared definitions for the gate-lab sequencers: FSM state encoding,
// pattern count and the reference three-input NOR.
package lab_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int         NUM_PATTERNS = 8;
    localparam logic [2:0] LAST_VEC     = 3'(NUM_PATTERNS - 1);

    // Expected gate output for input pattern {a,b,c}
    function automatic logic nor3_ref(input logic [2:0] vec);
        return ~(vec[2] | vec[1] | vec[0]);
    endfunction

endpackage

// File: rtl/nor_response_checker.sv
// Combinational response check for the NOR gate under test: flags a pattern
// when either of the two gate outputs disagrees with the reference NOR.
module nor_response_checker
    import lab_pkg::*;
(
    input  logic [2:0] vec,
    input  logic       d_in,
    input  logic       e_in,
    output logic       mismatch
);

    logic exp_s;

    // Reference value and single per-pattern mismatch flag (d and e wrong still counts once)
    always_comb begin
        exp_s    = nor3_ref(vec);
        mismatch = (d_in != exp_s) | (e_in != exp_s);
    end

endmodule

// File: rtl/nor_pattern_sequencer.sv
// Drives the three-input NOR gate through all eight input patterns (c fastest),
// holds each pattern HOLD_CYCLES clocks, samples d/e on the last hold cycle and
// accumulates a pass/fail summary for the run.
module nor_pattern_sequencer
    import lab_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    input  logic       d_in,
    input  logic       e_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic       first_fail_valid,
    output logic [2:0] first_fail_vec
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    state_t           state_r;
    state_t           next_state_s;
    logic [2:0]       vec_r;
    logic [CNT_W-1:0] hold_r;
    logic             busy_r;
    logic             done_r;
    logic             pass_r;
    logic [3:0]       err_count_r;
    logic             ff_valid_r;
    logic [2:0]       ff_vec_r;

    logic             mismatch_s;
    logic             hold_last_s;
    logic             accept_s;
    logic             sample_s;
    logic             finish_s;

    nor_response_checker u_checker (
        .vec      (vec_r),
        .d_in     (d_in),
        .e_in     (e_in),
        .mismatch (mismatch_s)
    );

    // Last cycle of the current pattern's hold window
    always_comb begin
        hold_last_s = (hold_r == HOLD_LAST);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic; start is only honoured outside RUN
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = RUN;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                if (hold_last_s && (vec_r == LAST_VEC)) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = RUN;
                end
            end
            DONE: begin
                if (start) begin
                    next_state_s = RUN;
                end else begin
                    next_state_s = DONE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // FSM control strobes for the datapath registers
    always_comb begin
        accept_s = 1'b0;
        sample_s = 1'b0;
        finish_s = 1'b0;
        case (state_r)
            IDLE: begin
                accept_s = start;
            end
            RUN: begin
                sample_s = hold_last_s;
                finish_s = hold_last_s & (vec_r == LAST_VEC);
            end
            DONE: begin
                accept_s = start;
            end
            default: begin
                accept_s = 1'b0;
                sample_s = 1'b0;
                finish_s = 1'b0;
            end
        endcase
    end

    // Pattern, hold counter and result registers; vec_r is forced to 000 outside RUN
    // so it can drive the gate inputs directly
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_r       <= 3'd0;
            hold_r      <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            err_count_r <= 4'd0;
            ff_valid_r  <= 1'b0;
            ff_vec_r    <= 3'd0;
        end else if (accept_s) begin
            vec_r       <= 3'd0;
            hold_r      <= '0;
            busy_r      <= 1'b1;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            err_count_r <= 4'd0;
            ff_valid_r  <= 1'b0;
            ff_vec_r    <= 3'd0;
        end else if (sample_s) begin
            hold_r <= '0;
            if (mismatch_s) begin
                err_count_r <= err_count_r + 4'd1;
                if (!ff_valid_r) begin
                    ff_valid_r <= 1'b1;
                    ff_vec_r   <= vec_r;
                end
            end
            if (finish_s) begin
                vec_r  <= 3'd0;
                busy_r <= 1'b0;
                done_r <= 1'b1;
                pass_r <= (err_count_r == 4'd0) && !mismatch_s;
            end else begin
                vec_r <= vec_r + 3'd1;
            end
        end else if (state_r == RUN) begin
            hold_r <= hold_r + CNT_W'(1);
        end
    end

    assign a                = vec_r[2];
    assign b                = vec_r[1];
    assign c                = vec_r[0];
    assign busy             = busy_r;
    assign done             = done_r;
    assign pass             = pass_r;
    assign err_count        = err_count_r;
    assign first_fail_valid = ff_valid_r;
    assign first_fail_vec   = ff_vec_r;

endmodule

// File: tb/tb_nor_pattern_sequencer.sv
// Scoreboard bench for nor_pattern_sequencer: stimulus pushes the expected
// pattern stream and run summary; a negedge monitor pops and compares.
module tb_nor_pattern_sequencer;

    localparam int HOLD = 4;

    typedef struct {
        logic [3:0] err;
        logic       pass;
        logic       ffv;
        logic [2:0] ffvec;
    } res_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       a, b, c;
    logic       d_in, e_in;
    logic       busy, done, pass;
    logic [3:0] err_count;
    logic       first_fail_valid;
    logic [2:0] first_fail_vec;

    int         mode = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    logic       done_q = 1'b0;

    logic [2:0] abc_q[$];
    res_t       res_q[$];

    nor_pattern_sequencer #(.HOLD_CYCLES(HOLD), .CNT_W(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .a                (a),
        .b                (b),
        .c                (c),
        .d_in             (d_in),
        .e_in             (e_in),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .err_count        (err_count),
        .first_fail_valid (first_fail_valid),
        .first_fail_vec   (first_fail_vec)
    );

    always #5 clk = ~clk;

    // Gate model: correct NOR or one of several planted gate faults
    always_comb begin
        case (mode)
            1:       begin d_in = ~(a | b | c); e_in = 1'b0;         end
            2:       begin d_in = a;            e_in = ~(a | b | c); end
            3:       begin d_in = ~(a | b | c); e_in = a | b | c;    end
            4:       begin d_in = ~(a | b);     e_in = ~(a | b | c); end
            default: begin d_in = ~(a | b | c); e_in = ~(a | b | c); end
        endcase
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic res_t mk(input int err, input int p, input int ffv, input int vec);
        res_t r;
        r.err   = 4'(err);
        r.pass  = 1'(p);
        r.ffv   = 1'(ffv);
        r.ffvec = 3'(vec);
        return r;
    endfunction

    task automatic push_run(input res_t r);
        for (int k = 0; k < 8; k++)
            for (int h = 0; h < HOLD; h++)
                abc_q.push_back(3'(k));
        res_q.push_back(r);
    endtask

    // Issue a start, check the accept-edge clearing, wait (bounded) for done
    task automatic run(input int m, input res_t r, input bit keep_start);
        int cycles;
        mode = m;
        push_run(r);
        start = 1'b1;
        @(posedge clk); #1;
        if (!keep_start) start = 1'b0;
        check("accept_busy", busy, 1);
        check("accept_done", done, 0);
        check("accept_pass", pass, 0);
        check("accept_err", err_count, 0);
        check("accept_ffv", first_fail_valid, 0);
        check("accept_abc", {a, b, c}, 0);
        cycles = 0;
        while (!done && cycles < 200) begin
            @(posedge clk); #1;
            cycles++;
        end
        start = 1'b0;
        check("done_latency", cycles, 8 * HOLD);
        check("done_busy", busy, 0);
    endtask

    // Monitor: compare driven pattern every busy cycle, run summary on done rise
    always @(negedge clk) begin
        if (busy === 1'b1) begin
            if (abc_q.size() == 0) begin
                check("abc_underflow", 1, 0);
            end else begin
                check("abc_seq", {a, b, c}, abc_q.pop_front());
            end
        end
        if (done === 1'b1 && done_q == 1'b0) begin
            if (res_q.size() == 0) begin
                check("res_underflow", 1, 0);
            end else begin
                res_t r;
                r = res_q.pop_front();
                check("res_err_count", err_count, r.err);
                check("res_pass", pass, r.pass);
                check("res_ffv", first_fail_valid, r.ffv);
                check("res_ffvec", first_fail_vec, r.ffvec);
                check("res_abc_idle", {a, b, c}, 0);
            end
        end
        done_q <= done;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_abc", {a, b, c}, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err", err_count, 0);
        check("rst_ffv", first_fail_valid, 0);
        check("rst_ffvec", first_fail_vec, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Correct gate, then faulty gates with hand-computed results
        run(0, mk(0, 1, 0, 0), 1'b0);
        run(1, mk(1, 0, 1, 0), 1'b0);
        run(2, mk(5, 0, 1, 0), 1'b0);
        run(4, mk(1, 0, 1, 1), 1'b0);

        // Reset mid-run during pattern 010
        mode = 0;
        for (int k = 0; k < 8; k++)
            for (int h = 0; h < HOLD; h++)
                abc_q.push_back(3'(k));
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("abort_abc_before", {a, b, c}, 2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        abc_q.delete();
        check("abort_abc", {a, b, c}, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_err", err_count, 0);
        check("abort_ffv", first_fail_valid, 0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_idle_busy", busy, 0);
        run(0, mk(0, 1, 0, 0), 1'b0);

        // start held high through the whole run
        run(0, mk(0, 1, 0, 0), 1'b1);

        // Failing run, frozen results, then restart from DONE
        run(3, mk(8, 0, 1, 0), 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("frozen_done", done, 1);
        check("frozen_err", err_count, 8);
        check("frozen_pass", pass, 0);
        check("frozen_busy", busy, 0);
        run(0, mk(0, 1, 0, 0), 1'b0);

        repeat (2) @(posedge clk);
        #1;
        check("abc_q_empty", abc_q.size(), 0);
        check("res_q_empty", res_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
